// File: rtl/pipe_mux_pkg.sv
// ============================================================================
// Module   : pipe_mux_pkg
// Brief    : Shared types, constants and helpers for the pipe_mux_stage block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_mux_pkg;

    localparam int c_beat_width = 5;

    // Link register index, the fixed destination candidate used by jal.
    localparam logic [4:0] RA_REG_IDX = 5'd31;

    typedef struct packed {
        logic [c_beat_width-1:0] data;
        logic                    err;
    } beat_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_mux_stage_if.sv
// ============================================================================
// Module   : pipe_mux_stage_if
// Brief    : Upstream/downstream valid-ready bus of the select stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_mux_stage_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/pipe_mux_stage_mux_n_sel.sv
// ============================================================================
// Module   : mux_n_sel
// Brief    : Combinational N:1 select; out-of-range index yields zero + err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_sel #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] cand,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = cand[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/pipe_mux_stage.sv
// ============================================================================
// Module   : pipe_mux_stage
// Brief    : Registered N-way select stage with valid/ready and a skid entry.
//            Optional stall counter port enabled by PIPE_MUX_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mux_stage
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pipe_mux_stage_if.slave        bus
`ifdef PIPE_MUX_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_accept;
    logic             w_load;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;
    logic             r_skid_valid;

    mux_n_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .cand (bus.in_data),
        .sel  (bus.in_sel),
        .data (w_sel_data),
        .err  (w_sel_err)
    );

    // in_ready depends only on the skid flag, keeping out_ready off this path.
    assign w_accept = bus.in_valid && !r_skid_valid && !flush;
    assign w_load   = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_err    <= r_skid_err;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_data   <= w_sel_data;
                r_out_err    <= w_sel_err;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_data  <= w_sel_data;
            r_skid_err   <= w_sel_err;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;
    assign bus.out_valid = r_out_valid;

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_mux_stage.sv
// ============================================================================
// Module   : tb_pipe_mux_stage
// Brief    : Directed + random bench for pipe_mux_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mux_stage;
    import pipe_mux_pkg::*;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = sel_width(NUM_IN);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    pipe_mux_stage_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_mux_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef PIPE_MUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int    n_checks = 0;
    int    n_errors = 0;

    // Reference: the stage is a 2-deep FIFO whose head is the visible output.
    beat_t q[$];
    beat_t shown;
    int    m_stall;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic beat_t expect_beat(input logic [NUM_IN*WIDTH-1:0] d, input int s);
        beat_t r;
        r.data = '0;
        r.err  = 1'b1;
        if (s < NUM_IN) begin
            r.data = d[s*WIDTH +: WIDTH];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        shown   = '0;
        m_stall = 0;
    endtask

    task automatic compare();
        beat_t cur;
        cur = (q.size() != 0) ? q[0] : shown;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
        check("out_data",  32'(bus.out_data),  32'(cur.data));
        check("out_err",   32'(bus.out_err),   32'(cur.err));
`ifdef PIPE_MUX_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic drive(input logic v, input int sel, input logic [4:0] c2, input logic [4:0] c1,
                         input logic [4:0] c0, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_sel    = SEL_W'(sel);
        bus.in_data   = {c2, c1, c0};
        bus.out_ready = rdy;
        flush         = fl;
    endtask

    task automatic tick();
        logic  acc;
        logic  stl;
        beat_t b;
        acc = bus.in_valid && (q.size() < 2) && !flush;
        stl = (q.size() != 0) && !bus.out_ready;
        b   = expect_beat(bus.in_data, int'(bus.in_sel));
        @(posedge clk);
        if (stl && m_stall < 65535) m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        if (q.size() != 0) shown = q[0];
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        int exp_stream[3];
        exp_stream[0] = 3;
        exp_stream[1] = 7;
        exp_stream[2] = 31;

        drive(1'b0, 0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Single beat, sel=1
        drive(1'b1, 1, RA_REG_IDX, 5'd7, 5'd3, 1'b1, 1'b0);
        tick();
        check("t1_data", 32'(bus.out_data), 32'd7);
        check("t1_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back streaming
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, RA_REG_IDX, 5'd7, 5'd3, 1'b1, 1'b0);
            tick();
            check($sformatf("t2_data%0d", i), 32'(bus.out_data), 32'(exp_stream[i]));
            check($sformatf("t2_valid%0d", i), 32'(bus.out_valid), 32'd1);
        end

        // Stall into skid, then drain
        drive(1'b1, 2, RA_REG_IDX, 5'd7, 5'd3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b0);
        tick();
        check("t3_hold", 32'(bus.out_data), 32'd31);
        check("t3_full", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        check("t3_drain", 32'(bus.out_data), 32'd3);
        check("t3_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("t3_empty", 32'(bus.out_valid), 32'd0);

        // Out-of-range select
        drive(1'b1, 3, RA_REG_IDX, 5'd7, 5'd3, 1'b1, 1'b0);
        tick();
        check("t4_err", 32'(bus.out_err), 32'd1);
        check("t4_data", 32'(bus.out_data), 32'd0);

        // Flush with both entries full and a beat incoming
        drive(1'b1, 0, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b1);
        tick();
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();

        // Stall counting, then asynchronous reset with the skid full
        do_reset();
        drive(1'b1, 0, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, RA_REG_IDX, 5'd7, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
`ifdef PIPE_MUX_STALL_CNT_EN
        check("t6_stall5", 32'(stall_cnt), 32'd5);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_data", 32'(bus.out_data), 32'd0);
        check("t6_ready", 32'(bus.in_ready), 32'd1);
`ifdef PIPE_MUX_STALL_CNT_EN
        check("t6_stall0", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  5'($urandom), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
